// File: rtl/cmd_sender.sv
// cmd_sender: fetches one newline-terminated command from a byte-wide
// command memory and pushes it, byte by byte, into a TX FIFO.
//
// Memory layout: byte 0 holds the number of valid commands; command n,
// byte i lives at n*CMD_WIDTH + 1 + i.  A command ends at the first 0x0A.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request to send the command selected by cmd_sel (IDLE only)
//   cmd_sel      command index, latched on an accepted start
//   mem_rd_en    command-memory read strobe (data returns one cycle later)
//   mem_addr     command-memory byte address
//   mem_rd_data  command-memory read data
//   tx_full      TX FIFO full; stalls the byte push while high
//   tx_wr_en     TX FIFO write strobe
//   tx_data      byte written to the TX FIFO
//   busy         high whenever the FSM is not IDLE
//   done         one-cycle pulse after the terminating LF has been written
//   error_code   0 no error, 1 bad index, 2 no terminator within the slot
//   error_pulse  one-cycle pulse whenever error_code is updated
module cmd_sender #(
  parameter int CMD_WIDTH = 32,
  parameter int CMD_DEPTH = 16,
  localparam int ADDR_W = $clog2(CMD_DEPTH * CMD_WIDTH),
  localparam int SEL_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  input  logic              tx_full,
  output logic              tx_wr_en,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error_code,
  output logic              error_pulse
);

  localparam int IDX_W = (CMD_WIDTH > 1) ? $clog2(CMD_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CMD_WIDTH - 1);
  // The last slot is reserved: its final byte would sit past the address range.
  localparam logic [31:0] LAST_SEL = 32'(CMD_DEPTH - 1);
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [1:0] NO_ERR      = 2'd0;
  localparam logic [1:0] ERR_INDEX   = 2'd1;
  localparam logic [1:0] ERR_NO_TERM = 2'd2;

  typedef enum logic [2:0] {
    IDLE, RD_CNT, WAIT_CNT, CHECK, RD_BYTE, WAIT_BYTE, PUSH, DONE
  } state_t;

  state_t state, state_nxt;

  logic [SEL_W-1:0]  sel_q;
  logic [7:0]        cnt_q;
  logic [7:0]        byte_q;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              sel_ld, cnt_ld, byte_ld;
  logic              index_bad;

  logic              mem_rd_en_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic              tx_wr_en_nxt;
  logic [7:0]        tx_data_nxt;
  logic              done_nxt;
  logic              error_pulse_nxt;
  logic [1:0]        error_code_nxt;

  function automatic logic [ADDR_W-1:0] byte_addr(input logic [SEL_W-1:0] sel,
                                                   input logic [IDX_W-1:0] i);
    return ADDR_W'(sel) * ADDR_W'(CMD_WIDTH) + ADDR_W'(1) + ADDR_W'(i);
  endfunction

  assign index_bad = (32'(sel_q) >= 32'(cnt_q)) || (32'(sel_q) >= LAST_SEL);
  assign busy      = (state != IDLE);

  // Next state plus the D side of every registered output.  The read strobe
  // and address are set on entry to RD_CNT/RD_BYTE so they are visible during
  // those states; the write strobe goes out the cycle after PUSH accepts.
  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    sel_ld          = 1'b0;
    cnt_ld          = 1'b0;
    byte_ld         = 1'b0;
    mem_rd_en_nxt   = 1'b0;
    mem_addr_nxt    = mem_addr;
    tx_wr_en_nxt    = 1'b0;
    tx_data_nxt     = tx_data;
    done_nxt        = 1'b0;
    error_pulse_nxt = 1'b0;
    error_code_nxt  = error_code;
    case (state)
      IDLE: begin
        if (start) begin
          sel_ld        = 1'b1;
          idx_nxt       = '0;
          mem_rd_en_nxt = 1'b1;
          mem_addr_nxt  = '0;
          state_nxt     = RD_CNT;
        end
      end
      RD_CNT:   state_nxt = WAIT_CNT;
      WAIT_CNT: begin
        cnt_ld    = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        if (index_bad) begin
          error_code_nxt  = ERR_INDEX;
          error_pulse_nxt = 1'b1;
          state_nxt       = IDLE;
        end else begin
          mem_rd_en_nxt = 1'b1;
          mem_addr_nxt  = byte_addr(sel_q, idx);
          state_nxt     = RD_BYTE;
        end
      end
      RD_BYTE:  state_nxt = WAIT_BYTE;
      WAIT_BYTE: begin
        byte_ld   = 1'b1;
        state_nxt = PUSH;
      end
      PUSH: begin
        // While the FIFO is full nothing changes: byte_q and idx simply hold.
        if (!tx_full) begin
          tx_wr_en_nxt = 1'b1;
          tx_data_nxt  = byte_q;
          if (byte_q == LF) begin
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end else if (idx == LAST_IDX) begin
            error_code_nxt  = ERR_NO_TERM;
            error_pulse_nxt = 1'b1;
            state_nxt       = IDLE;
          end else begin
            idx_nxt       = idx + IDX_W'(1);
            mem_rd_en_nxt = 1'b1;
            mem_addr_nxt  = byte_addr(sel_q, idx_nxt);
            state_nxt     = RD_BYTE;
          end
        end
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      tx_wr_en    <= 1'b0;
      tx_data     <= '0;
      done        <= 1'b0;
      error_pulse <= 1'b0;
      error_code  <= NO_ERR;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      mem_rd_en   <= mem_rd_en_nxt;
      mem_addr    <= mem_addr_nxt;
      tx_wr_en    <= tx_wr_en_nxt;
      tx_data     <= tx_data_nxt;
      done        <= done_nxt;
      error_pulse <= error_pulse_nxt;
      error_code  <= error_code_nxt;
    end
  end

  // Datapath captures; each is always loaded before it is consumed.
  always_ff @(posedge clk) begin
    if (sel_ld)  sel_q  <= cmd_sel;
    if (cnt_ld)  cnt_q  <= mem_rd_data;
    if (byte_ld) byte_q <= mem_rd_data;
  end

endmodule

// File: tb/tb_cmd_sender.sv
module tb_cmd_sender;

  localparam int CMD_WIDTH = 32;
  localparam int CMD_DEPTH = 16;
  localparam int ADDR_W    = $clog2(CMD_DEPTH * CMD_WIDTH);
  localparam int SEL_W     = $clog2(CMD_DEPTH);
  localparam int MEM_SIZE  = CMD_DEPTH * CMD_WIDTH;
  localparam int K_BYTE = 0, K_DONE = 1, K_ERR = 2;

  typedef struct { int kind; int val; } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [SEL_W-1:0]  cmd_sel = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data = 8'h00;
  logic              tx_full;
  logic              tx_wr_en;
  logic [7:0]        tx_data;
  logic              busy;
  logic              done;
  logic [1:0]        error_code;
  logic              error_pulse;

  logic       full_force = 1'b0;
  logic       full_rand  = 1'b0;
  logic       rnd_full   = 1'b0;
  logic       full_prev  = 1'b0;
  logic [7:0] mem [0:MEM_SIZE-1];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   start_cyc = 0;
  int   exp_err = 0;
  exp_t exp_q[$];
  int   wr_cyc_q[$];
  int   rd_addr_q[$];

  assign tx_full = full_force | rnd_full;

  cmd_sender #(.CMD_WIDTH(CMD_WIDTH), .CMD_DEPTH(CMD_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_sel(cmd_sel),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .tx_full(tx_full), .tx_wr_en(tx_wr_en), .tx_data(tx_data),
    .busy(busy), .done(done), .error_code(error_code), .error_pulse(error_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) full_prev <= tx_full;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  always @(negedge clk) rnd_full = full_rand ? ($urandom_range(0, 2) == 0) : 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  task automatic push(input int k, input int v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Reference behaviour: what a send of slot `sel` must produce, from memory.
  task automatic model(input int sel);
    int cnt;
    int b;
    cnt = int'(mem[0]);
    if (sel >= cnt || sel >= CMD_DEPTH - 1) begin
      push(K_ERR, 1);
      exp_err = 1;
    end else begin
      for (int i = 0; i < CMD_WIDTH; i++) begin
        b = int'(mem[sel * CMD_WIDTH + 1 + i]);
        push(K_BYTE, b);
        if (b == 8'h0A) begin
          push(K_DONE, 0);
          break;
        end
        if (i == CMD_WIDTH - 1) begin
          push(K_ERR, 2);
          exp_err = 2;
        end
      end
    end
  endtask

  // Scoreboard monitor: every strobe from the DUT must match the next expectation.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_rd_en) rd_addr_q.push_back(int'(mem_addr));
      if (tx_wr_en) begin
        wr_cnt++;
        wr_cyc_q.push_back(cyc);
        chk("tx_while_full", int'(full_prev), 0);
        if (exp_q.size() == 0) chk("tx_unexpected", (K_BYTE << 8) | int'(tx_data), -1);
        else begin
          e = exp_q.pop_front();
          chk("tx_byte", (K_BYTE << 8) | int'(tx_data), (e.kind << 8) | e.val);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) chk("done_unexpected", K_DONE << 8, -1);
        else begin
          e = exp_q.pop_front();
          chk("done_pulse", K_DONE << 8, (e.kind << 8) | e.val);
        end
      end
      if (error_pulse) begin
        if (exp_q.size() == 0) chk("err_unexpected", (K_ERR << 8) | int'(error_code), -1);
        else begin
          e = exp_q.pop_front();
          chk("err_pulse", (K_ERR << 8) | int'(error_code), (e.kind << 8) | e.val);
        end
      end
    end
  endtask

  task automatic send(input int sel);
    @(negedge clk);
    start     = 1'b1;
    cmd_sel   = SEL_W'(sel);
    start_cyc = cyc;
    model(sel);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, int'(busy), 0);
    repeat (3) @(negedge clk);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic put(input int slot, input int i, input int v);
    mem[slot * CMD_WIDTH + 1 + i] = 8'(v);
  endtask

  task automatic fill_random();
    int lf;
    logic [7:0] b;
    mem[0] = 8'($urandom_range(0, CMD_DEPTH));
    for (int n = 0; n < CMD_DEPTH - 1; n++) begin
      lf = $urandom_range(0, CMD_WIDTH + 8);
      for (int i = 0; i < CMD_WIDTH; i++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0A) b = 8'h0B;
        if (i == lf) b = 8'h0A;
        put(n, i, int'(b));
      end
    end
  endtask

  initial begin
    int base;
    int sel;
    fork
      monitor();
    join_none

    for (int a = 0; a < MEM_SIZE; a++) mem[a] = 8'h55;

    // Asynchronous reset, checked before the first clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error_pulse", int'(error_pulse), 0);
    chk("rst_error_code", int'(error_code), 0);
    chk("rst_tx_wr_en", int'(tx_wr_en), 0);
    chk("rst_mem_rd_en", int'(mem_rd_en), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // "AT\r\n" from slot 0: latency, spacing and successful completion.
    mem[0] = 8'd7;
    put(0, 0, 8'h41); put(0, 1, 8'h54); put(0, 2, 8'h0D); put(0, 3, 8'h0A);
    wr_cyc_q.delete();
    send(0);
    wait_idle("at", 200);
    chk("at_first_latency", wr_cyc_q.size() > 0 ? wr_cyc_q[0] - start_cyc : -1, 7);
    chk("at_byte_spacing", wr_cyc_q.size() > 1 ? wr_cyc_q[1] - wr_cyc_q[0] : -1, 3);
    chk("at_write_count", wr_cyc_q.size(), 4);
    chk("at_error_code", int'(error_code), 0);

    // Index errors: index equal to the count, and the reserved last slot.
    base = wr_cnt;
    send(7);
    wait_idle("idx7", 200);
    chk("idx7_error_code", int'(error_code), 1);
    chk("idx7_no_writes", wr_cnt - base, 0);
    mem[0] = 8'd16;
    base = wr_cnt;
    send(15);
    wait_idle("idx15", 200);
    chk("idx15_error_code", int'(error_code), 1);
    chk("idx15_no_writes", wr_cnt - base, 0);

    // Slot 2 full of spaces with no terminator.
    mem[0] = 8'd7;
    for (int i = 0; i < CMD_WIDTH; i++) put(2, i, 8'h20);
    base = wr_cnt;
    send(2);
    wait_idle("noterm", 400);
    chk("noterm_error_code", int'(error_code), 2);
    chk("noterm_writes", wr_cnt - base, 32);

    // FIFO full held while byte 1 is pending.
    put(3, 0, 8'h48); put(3, 1, 8'h45); put(3, 2, 8'h4C);
    put(3, 3, 8'h4C); put(3, 4, 8'h4F); put(3, 5, 8'h0A);
    base = wr_cnt;
    wr_cyc_q.delete();
    send(3);
    for (int k = 0; k < 100 && wr_cnt < base + 1; k++) @(negedge clk);
    full_force = 1'b1;
    repeat (5) @(negedge clk);
    full_force = 1'b0;
    wait_idle("full", 400);
    chk("full_writes", wr_cnt - base, 6);
    chk("full_stall_seen", (wr_cyc_q.size() > 1) ? int'(wr_cyc_q[1] - wr_cyc_q[0] > 3) : 0, 1);

    // Reset after the second byte, then a full resend of slot 1.
    for (int i = 0; i < 10; i++) put(1, i, 8'h30 + i);
    put(1, 10, 8'h0A);
    base = wr_cnt;
    send(1);
    for (int k = 0; k < 100 && wr_cnt < base + 2; k++) @(negedge clk);
    chk("rst_mid_reached", wr_cnt - base, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_tx_wr_en", int'(tx_wr_en), 0);
    chk("rst_mid_mem_rd_en", int'(mem_rd_en), 0);
    exp_q.delete();
    exp_err = 0;
    base = wr_cnt;
    repeat (3) @(negedge clk);
    chk("rst_mid_no_writes", wr_cnt - base, 0);
    rst_n = 1'b1;
    rd_addr_q.delete();
    send(1);
    wait_idle("resend", 200);
    chk("resend_first_byte_addr", rd_addr_q.size() > 1 ? rd_addr_q[1] : -1, 33);
    chk("resend_writes", wr_cnt - base, 11);
    chk("resend_error_code", int'(error_code), 0);

    // start hammered with random indices while busy.
    put(4, 0, 8'h4F); put(4, 1, 8'h4B); put(4, 2, 8'h0D); put(4, 3, 8'h0A);
    base = wr_cnt;
    @(negedge clk);
    start   = 1'b1;
    cmd_sel = SEL_W'(4);
    model(4);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) break;
      start   = 1'b1;
      cmd_sel = SEL_W'($urandom_range(0, CMD_DEPTH - 1));
    end
    start = 1'b0;
    wait_idle("hammer", 200);
    chk("hammer_writes", wr_cnt - base, 4);

    // Randomized commands, memory contents and FIFO back-pressure.
    full_rand = 1'b1;
    for (int t = 0; t < 25; t++) begin
      fill_random();
      sel = $urandom_range(0, CMD_DEPTH - 1);
      send(sel);
      wait_idle("rand", 2000);
      chk("rand_error_code", int'(error_code), exp_err);
    end
    full_rand = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_sender.md
CMD_SENDER -- requirements
Module: cmd_sender

Interface
REQ-001 SHALL have parameter CMD_WIDTH, default 32, bytes per command slot.
REQ-002 SHALL have parameter CMD_DEPTH, default 16, command slots in memory; ADDR_W = $clog2(CMD_DEPTH*CMD_WIDTH), 9 at defaults.
REQ-003 SHALL have one clock and an asynchronous active-low reset, as listed in REQ-004 and REQ-005.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request to send one command.
REQ-007 SHALL have port cmd_sel, input, $clog2(CMD_DEPTH) bits: index of the command to send.
REQ-008 SHALL have port mem_rd_en, output, 1 bit: command-memory read strobe.
REQ-009 SHALL have port mem_addr, output, ADDR_W bits: command-memory byte address.
REQ-010 SHALL have port mem_rd_data, input, 8 bits: read data, valid exactly 1 cycle after mem_rd_en.
REQ-011 SHALL have port tx_full, input, 1 bit: TX FIFO full.
REQ-012 SHALL have port tx_wr_en, output, 1 bit: TX FIFO write strobe.
REQ-013 SHALL have port tx_data, output, 8 bits: byte written to the TX FIFO.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1 bit: 1-cycle pulse on successful send.
REQ-016 SHALL have port error_code, output, 2 bits: 0 NO_ERR, 1 ERR_INDEX, 2 ERR_NO_TERM.
REQ-017 SHALL have port error_pulse, output, 1 bit: 1-cycle pulse when error_code is updated.

Function
REQ-018 Memory map SHALL be: address 0 = valid-command count; command n byte i at n*CMD_WIDTH + 1 + i.
REQ-019 FSM states SHALL be IDLE, RD_CNT, WAIT_CNT, CHECK, RD_BYTE, WAIT_BYTE, PUSH, DONE.
REQ-020 In IDLE, start=1 SHALL latch cmd_sel, clear the byte index, and go to RD_CNT; start=0 SHALL hold IDLE.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the latched index or the state.
REQ-022 RD_CNT SHALL assert mem_rd_en with mem_addr=0 for one cycle and then go to WAIT_CNT.
REQ-023 WAIT_CNT SHALL capture mem_rd_data as the count and go to CHECK.
REQ-024 CHECK SHALL flag ERR_INDEX (error_code=1, error_pulse=1, then IDLE) when latched index >= count or >= CMD_DEPTH-1.
REQ-025 CHECK SHALL otherwise go to RD_BYTE.
REQ-026 RD_BYTE SHALL assert mem_rd_en with mem_addr = sel*CMD_WIDTH+1+idx, computed at ADDR_W width, then go to WAIT_BYTE.
REQ-027 WAIT_BYTE SHALL capture mem_rd_data into a byte register and go to PUSH.
REQ-028 PUSH with tx_full=1 SHALL stall, holding the byte with no write and no loss, for any number of cycles.
REQ-029 PUSH with tx_full=0 SHALL assert tx_wr_en for exactly one cycle with tx_data = the captured byte.
REQ-030 After that write, byte 0x0A (LF) SHALL go to DONE.
REQ-031 After that write, otherwise at idx = CMD_WIDTH-1, the block SHALL flag ERR_NO_TERM (error_code=2, pulse) and go to IDLE; bytes already written stay in the FIFO.
REQ-032 After that write, otherwise idx SHALL increment and the FSM SHALL go to RD_BYTE.
REQ-033 DONE SHALL pulse done for one cycle and go to IDLE; error_code SHALL be left unchanged.
REQ-034 Best-case throughput SHALL be 1 byte per 3 cycles; start-to-first-tx_wr_en latency SHALL be 7 cycles with tx_full=0.
REQ-035 tx_wr_en, mem_rd_en, done and error_pulse SHALL be registered and default to 0 every cycle.
REQ-036 An unreachable state encoding SHALL return to IDLE on the next cycle.

Reset
REQ-037 On rst_n=0, asynchronously: state=IDLE, busy=0, done=0, error_pulse=0, error_code=0, tx_wr_en=0, mem_rd_en=0, mem_addr=0, tx_data=0, idx=0.
REQ-038 Reset mid-send SHALL abort with no further writes; the next start SHALL restart from byte 0.

Verification
REQ-039 count=7, slot 0="AT\r\n", start with cmd_sel=0 -> tx bytes 0x41,0x54,0x0D,0x0A, first write 7 cycles after start, done pulse once, error_code=0.
REQ-040 count=7, cmd_sel=7; then count=16, cmd_sel=15 -> each: error_code=1, error_pulse once, zero tx_wr_en, return to IDLE.
REQ-041 slot 2 = 32 bytes 0x20 with no LF -> 32 writes of 0x20, then error_code=2 with pulse, no done.
REQ-042 tx_full held high for 5 cycles during byte 1 -> no write while full, byte written once after release, full sequence intact.
REQ-043 rst_n low after 2nd byte; then start cmd_sel=1 -> no writes during reset, resend starts at address 33 and completes.
REQ-044 start pulsed every cycle while busy -> exactly one command sent, latched index unchanged.
